// File: rtl/delay_line_bank.sv
// delay_line_bank: fractional delay lines carved out of one shared RAM.
// Each op writes one sample and returns an interpolated, faded-in tap.
module delay_line_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int N_CHANNELS = 16,
    parameter int MEM_DEPTH  = 4096,
    parameter int FRAC_BITS  = 8,
    parameter int GAIN_STEP  = 64,
    localparam int HANDLE_W  = $clog2(N_CHANNELS),
    localparam int ADDR_W    = $clog2(MEM_DEPTH),
    localparam int D_W       = ADDR_W + FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         alloc_req,
    input  logic [ADDR_W-1:0]            alloc_size,
    input  logic [D_W-1:0]               alloc_delay,
    output logic                         alloc_ack,
    output logic [HANDLE_W-1:0]          alloc_handle,
    output logic                         alloc_invalid,
    input  logic                         proc_req,
    output logic                         proc_ready,
    input  logic [HANDLE_W-1:0]          proc_handle,
    input  logic signed [DATA_WIDTH-1:0] proc_sample,
    input  logic [D_W-1:0]               proc_delay_inc,
    output logic signed [DATA_WIDTH-1:0] proc_out,
    output logic                         proc_out_valid,
    output logic                         proc_invalid
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_TAP1   = 3'd2;
    localparam logic [2:0] S_CAPT   = 3'd3;
    localparam logic [2:0] S_INTERP = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;
    localparam int DW = D_W + 2;
    localparam logic [HANDLE_W:0] NCH   = (HANDLE_W+1)'(N_CHANNELS);
    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [14:0]       G_ONE = 15'd16384;

    logic [2:0]            state_q, state_d;
    logic [HANDLE_W:0]     n_alloc_q;
    logic [ADDR_W:0]       next_base_q;
    logic [ADDR_W-1:0]     base_q  [N_CHANNELS];
    logic [ADDR_W-1:0]     size_q  [N_CHANNELS];
    logic [ADDR_W-1:0]     pos_q   [N_CHANNELS];
    logic [D_W-1:0]        delay_q [N_CHANNELS];
    logic                  wrap_q  [N_CHANNELS];
    logic [14:0]           gain_q  [N_CHANNELS];
    logic [HANDLE_W-1:0]   h_q, ahandle_q;
    logic signed [DATA_WIDTH-1:0] x_q, a_q, b_q, y_q, out_q;
    logic                  ack_q, ainv_q, pinv_q, val_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  idle, alloc_ok, proc_ok, mem_we;
    logic [ADDR_W:0]       end_sum, t0, t1;
    logic [ADDR_W-1:0]     d_int, off0, off1, wa, ra;
    logic [FRAC_BITS-1:0]  frac;
    logic signed [DW-1:0]  dsum;
    logic [D_W-1:0]        new_d, alloc_d;
    logic signed [DATA_WIDTH:0] diff;
    logic signed [DATA_WIDTH+FRAC_BITS+1:0] wprod;
    logic signed [DATA_WIDTH-1:0] y_d, out_d;
    logic [16:0]           gsum;
    logic [14:0]           gstep, geff;
    logic signed [DATA_WIDTH+15:0] gprod;

    function automatic logic [D_W-1:0] clamp_d(input logic signed [DW-1:0] v,
                                               input logic [ADDR_W-1:0] sz);
        logic signed [DW-1:0] lo, hi;
        lo = $signed({{(DW-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}});
        hi = $signed({2'b00, sz - ADDR_W'(1), {FRAC_BITS{1'b0}}});
        if (v < lo)      clamp_d = lo[D_W-1:0];
        else if (v > hi) clamp_d = hi[D_W-1:0];
        else             clamp_d = v[D_W-1:0];
    endfunction

    assign idle       = (state_q == S_IDLE);
    assign proc_ready = idle & ~alloc_req & ~clear;
    assign end_sum    = next_base_q + {1'b0, alloc_size};
    assign alloc_ok   = (n_alloc_q < NCH) && (alloc_size >= ADDR_W'(2))
                        && (end_sum <= DEPTH);
    assign proc_ok    = ({1'b0, proc_handle} < n_alloc_q);
    assign alloc_d    = clamp_d($signed({2'b00, alloc_delay}), alloc_size);

    always_comb begin
        dsum  = $signed({2'b00, delay_q[proc_handle]})
              + $signed({{2{proc_delay_inc[D_W-1]}}, proc_delay_inc});
        new_d = clamp_d(dsum, size_q[proc_handle]);
        d_int = delay_q[h_q][D_W-1:FRAC_BITS];
        frac  = delay_q[h_q][FRAC_BITS-1:0];
        // Taps sit behind the write pointer; one conditional add wraps them.
        t0    = {1'b0, pos_q[h_q]} - {1'b0, d_int};
        t1    = t0 - (ADDR_W+1)'(1);
        off0  = t0[ADDR_W] ? t0[ADDR_W-1:0] + size_q[h_q] : t0[ADDR_W-1:0];
        off1  = t1[ADDR_W] ? t1[ADDR_W-1:0] + size_q[h_q] : t1[ADDR_W-1:0];
        mem_we = (state_q == S_WRITE);
        wa    = base_q[h_q] + pos_q[h_q];
        ra    = base_q[h_q] + ((state_q == S_TAP1) ? off1 : off0);
        diff  = {b_q[DATA_WIDTH-1], b_q} - {a_q[DATA_WIDTH-1], a_q};
        wprod = diff * $signed({1'b0, frac});
        y_d   = a_q + DATA_WIDTH'(wprod >>> FRAC_BITS);
        gsum  = {2'b00, gain_q[h_q]} + 17'(GAIN_STEP);
        gstep = (gsum > {2'b00, G_ONE}) ? G_ONE : gsum[14:0];
        geff  = wrap_q[h_q] ? gstep : gain_q[h_q];
        gprod = y_q * $signed({1'b0, geff});
        out_d = DATA_WIDTH'(gprod >>> 14);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (proc_ready && proc_req && proc_ok) state_d = S_WRITE;
            S_WRITE:  state_d = S_TAP1;
            S_TAP1:   state_d = S_CAPT;
            S_CAPT:   state_d = S_INTERP;
            S_INTERP: state_d = S_OUT;
            S_OUT:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            if (mem_we) mem[wa] <= x_q;
            rdata_q <= mem[ra];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            n_alloc_q   <= '0;
            next_base_q <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                base_q[i]  <= '0;
                size_q[i]  <= '0;
                pos_q[i]   <= '0;
                delay_q[i] <= '0;
                wrap_q[i]  <= 1'b0;
                gain_q[i]  <= '0;
            end
            h_q       <= '0;
            ahandle_q <= '0;
            x_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            y_q       <= '0;
            out_q     <= '0;
            ack_q     <= 1'b0;
            ainv_q    <= 1'b0;
            pinv_q    <= 1'b0;
            val_q     <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            ainv_q <= 1'b0;
            pinv_q <= 1'b0;
            val_q  <= 1'b0;
            if (enable) begin
                state_q <= state_d;
                if (idle && clear) begin
                    n_alloc_q   <= '0;
                    next_base_q <= '0;
                end else if (idle && alloc_req) begin
                    if (alloc_ok) begin
                        base_q[n_alloc_q[HANDLE_W-1:0]]  <= next_base_q[ADDR_W-1:0];
                        size_q[n_alloc_q[HANDLE_W-1:0]]  <= alloc_size;
                        pos_q[n_alloc_q[HANDLE_W-1:0]]   <= '0;
                        wrap_q[n_alloc_q[HANDLE_W-1:0]]  <= 1'b0;
                        gain_q[n_alloc_q[HANDLE_W-1:0]]  <= '0;
                        delay_q[n_alloc_q[HANDLE_W-1:0]] <= alloc_d;
                        ahandle_q   <= n_alloc_q[HANDLE_W-1:0];
                        n_alloc_q   <= n_alloc_q + 1'b1;
                        next_base_q <= end_sum;
                        ack_q       <= 1'b1;
                    end else begin
                        ainv_q <= 1'b1;
                    end
                end else if (proc_ready && proc_req) begin
                    if (proc_ok) begin
                        h_q <= proc_handle;
                        x_q <= proc_sample;
                        delay_q[proc_handle] <= new_d;
                    end else begin
                        pinv_q <= 1'b1;
                    end
                end
                if (state_q == S_TAP1)   a_q <= $signed(rdata_q);
                if (state_q == S_CAPT)   b_q <= $signed(rdata_q);
                if (state_q == S_INTERP) y_q <= y_d;
                if (state_q == S_OUT) begin
                    out_q <= out_d;
                    val_q <= 1'b1;
                    gain_q[h_q] <= geff;
                    if (pos_q[h_q] == size_q[h_q] - ADDR_W'(1)) begin
                        pos_q[h_q]  <= '0;
                        wrap_q[h_q] <= 1'b1;
                    end else begin
                        pos_q[h_q] <= pos_q[h_q] + ADDR_W'(1);
                    end
                end
            end
        end
    end

    assign alloc_ack      = ack_q & enable;
    assign alloc_invalid  = ainv_q & enable;
    assign alloc_handle   = ahandle_q;
    assign proc_invalid   = pinv_q & enable;
    assign proc_out_valid = val_q & enable;
    assign proc_out       = out_q;

endmodule

// File: tb/tb_delay_line_bank.sv
// Directed bench for delay_line_bank with a scoreboard of expected taps.
module tb_delay_line_bank;

    logic              clk = 1'b0;
    logic              reset, enable, clear, alloc_req, proc_req;
    logic [4:0]        alloc_size;
    logic [12:0]       alloc_delay, proc_delay_inc;
    logic              alloc_ack, alloc_invalid, proc_ready;
    logic              proc_out_valid, proc_invalid;
    logic [1:0]        alloc_handle, proc_handle;
    logic signed [15:0] proc_sample, proc_out;

    int n_assert = 0;
    int n_fail = 0;
    int sb[$];

    always #5 clk = ~clk;

    delay_line_bank #(
        .DATA_WIDTH(16), .N_CHANNELS(4), .MEM_DEPTH(32),
        .FRAC_BITS(8), .GAIN_STEP(16384)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .alloc_req(alloc_req), .alloc_size(alloc_size),
        .alloc_delay(alloc_delay), .alloc_ack(alloc_ack),
        .alloc_handle(alloc_handle), .alloc_invalid(alloc_invalid),
        .proc_req(proc_req), .proc_ready(proc_ready),
        .proc_handle(proc_handle), .proc_sample(proc_sample),
        .proc_delay_inc(proc_delay_inc), .proc_out(proc_out),
        .proc_out_valid(proc_out_valid), .proc_invalid(proc_invalid)
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_op(input int size, input int dly, input int ok,
                            input int h, input string tag);
        alloc_size = 5'(size);
        alloc_delay = 13'(dly);
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        check({tag, "_ack"}, int'(alloc_ack), ok);
        check({tag, "_inv"}, int'(alloc_invalid), 1 - ok);
        if (ok == 1) check({tag, "_h"}, int'(alloc_handle), h);
    endtask

    task automatic proc_op(input int h, input int x, input int inc,
                           input int exp_v, input string tag);
        int lat;
        int e;
        sb.push_back(exp_v);
        proc_handle = 2'(h);
        proc_sample = 16'(x);
        proc_delay_inc = 13'(inc);
        proc_req = 1'b1;
        tick();
        proc_req = 1'b0;
        lat = 0;
        while (!proc_out_valid && lat < 12) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, lat, 5);
        check({tag, "_rdy"}, int'(proc_ready), 1);
        check(tag, int'(proc_out), e);
    endtask

    task automatic proc_bad(input int h, input string tag);
        int seen;
        proc_handle = 2'(h);
        proc_sample = 16'(1234);
        proc_delay_inc = '0;
        proc_req = 1'b1;
        tick();
        proc_req = 1'b0;
        check({tag, "_inv"}, int'(proc_invalid), 1);
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            seen += int'(proc_out_valid);
            tick();
        end
        check({tag, "_noval"}, seen, 0);
        check({tag, "_pulse"}, int'(proc_invalid), 0);
    endtask

    initial begin
        int seen;
        reset = 1'b0;
        enable = 1'b1;
        clear = 1'b0;
        alloc_req = 1'b0;
        proc_req = 1'b0;
        alloc_size = '0;
        alloc_delay = '0;
        proc_handle = '0;
        proc_sample = '0;
        proc_delay_inc = '0;
        repeat (3) tick();
        check("rst_out", int'(proc_out), 0);
        check("rst_val", int'(proc_out_valid), 0);
        check("rst_ack", int'(alloc_ack), 0);
        reset = 1'b1;
        tick();
        check("rst_rdy", int'(proc_ready), 1);

        alloc_op(8, 'h200, 1, 0, "al0");
        alloc_op(8, 'h200, 1, 1, "al1");
        alloc_op(20, 'h200, 0, 0, "al_big");
        alloc_op(16, 'h200, 1, 2, "al_fit");
        alloc_op(2, 'h200, 0, 0, "al_full_mem");

        for (int n = 0; n < 16; n++)
            proc_op(0, n * 10, 0, (n >= 8) ? (n - 2) * 10 : 0,
                    $sformatf("d2_n%0d", n));

        clear = 1'b1;
        tick();
        clear = 1'b0;
        proc_bad(0, "after_clear");

        alloc_op(8, 'h180, 1, 0, "re_al0");
        alloc_op(2, 0, 1, 1, "re_al1");
        alloc_op(1, 'h100, 0, 0, "al_size1");
        proc_bad(3, "bad_h3");

        for (int n = 0; n < 16; n++)
            proc_op(0, n * 100, (n == 0) ? 0 : 0, (n >= 8) ? n * 100 - 150 : 0,
                    $sformatf("ramp_n%0d", n));
        proc_op(0, 1600, 4095, 900, "clamp_hi");
        proc_op(0, 1700, -4095, 1600, "clamp_lo");
        proc_op(0, 1800, 0, 1700, "d1");

        for (int m = 0; m < 5; m++)
            proc_op(1, -1000 * (m + 1), 0, (m >= 2) ? -1000 * m : 0,
                    $sformatf("ch1_m%0d", m));

        alloc_size = 5'd2;
        alloc_delay = 13'h100;
        alloc_req = 1'b1;
        proc_handle = 2'd0;
        proc_sample = 16'sd1900;
        proc_delay_inc = '0;
        proc_req = 1'b1;
        #1;
        check("coll_rdy", int'(proc_ready), 0);
        tick();
        alloc_req = 1'b0;
        proc_req = 1'b0;
        check("coll_ack", int'(alloc_ack), 1);
        check("coll_h", int'(alloc_handle), 2);
        proc_op(0, 1900, 0, 1800, "coll_proc");

        alloc_op(2, 'h100, 1, 3, "al3");
        alloc_op(2, 'h100, 0, 0, "al_full_ch");

        enable = 1'b0;
        proc_handle = 2'd0;
        proc_sample = 16'sd7777;
        proc_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            seen += int'(proc_out_valid) + int'(proc_invalid);
        end
        proc_req = 1'b0;
        enable = 1'b1;
        check("en_hold", seen, 0);
        proc_op(0, 2000, 0, 1900, "en_resume");

        proc_handle = 2'd0;
        proc_sample = 16'sd555;
        proc_req = 1'b1;
        tick();
        proc_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen += int'(proc_out_valid);
        end
        check("rst_mid_noval", seen, 0);
        check("rst_mid_out", int'(proc_out), 0);
        reset = 1'b1;
        tick();
        proc_bad(0, "rst_mid_bad");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
